// File: rtl/chess_pkg.sv
// Shared chess-board definitions: command encoding, move-entry FSM states
// and the board coordinate limit used by the cursor counter.
package chess_pkg;

  // Largest file/rank index on an 8x8 board.
  localparam int BOARD_MAX = 7;

  typedef enum logic [1:0] {
    CMD_UP     = 2'b00,
    CMD_DOWN   = 2'b01,
    CMD_NEXT   = 2'b10,
    CMD_CANCEL = 2'b11
  } cmd_t;

  // The four editing states are numbered so their low two bits equal the
  // field index shown to the player.
  typedef enum logic [2:0] {
    SRC_FILE = 3'd0,
    SRC_RANK = 3'd1,
    DST_FILE = 3'd2,
    DST_RANK = 3'd3,
    COMMIT   = 3'd4
  } entry_state_t;

endpackage

// File: rtl/wrap_counter8.sv
// 3-bit up/down counter wrapping 7 <-> 0, used as the shared cursor.
// Ports:
//   clk, reset : clock, asynchronous active-high reset (count -> 0)
//   en         : step the counter this cycle
//   up         : direction when en=1 (1 = +1, 0 = -1)
//   clr        : synchronous clear to 0, takes priority over en
//   count      : current value
module wrap_counter8
  import chess_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       up,
  input  logic       clr,
  output logic [2:0] count
);

  localparam logic [2:0] MAX_VAL = 3'(BOARD_MAX);

  logic [2:0] count_q;
  logic [2:0] count_d;

  always_comb begin
    // NOTE: the default assignment comes first so every path through the
    // block drives count_d; a missing branch would otherwise infer a latch.
    count_d = count_q;
    if (clr) begin
      count_d = 3'd0;
    end else if (en) begin
      if (up) count_d = (count_q == MAX_VAL) ? 3'd0 : count_q + 3'd1;
      else    count_d = (count_q == 3'd0) ? MAX_VAL : count_q - 3'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= 3'd0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/move_entry_ctrl.sv
// Turn-based move-entry controller. Grants the shared cursor to the player
// on turn, walks source file/rank and destination file/rank, then strobes
// the packed move for one cycle and hands the turn over.
// Ports:
//   clk, reset         : clock, asynchronous active-high reset
//   w_valid/w_cmd      : white command request (UP/DOWN/NEXT/CANCEL)
//   w_ready            : white command accepted this cycle
//   b_valid/b_cmd      : black command request
//   b_ready            : black command accepted this cycle
//   turn               : 0 = white, 1 = black
//   field              : field being edited (0 src file .. 3 dst rank)
//   cursor             : current cursor value 0..7
//   disp_digit         : {0, cursor} for the seven-segment decoder
//   move_valid         : one-cycle move strobe
//   move_src, move_dst : {rank, file} of each square, valid with move_valid
module move_entry_ctrl
  import chess_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       w_valid,
  input  logic [1:0] w_cmd,
  output logic       w_ready,
  input  logic       b_valid,
  input  logic [1:0] b_cmd,
  output logic       b_ready,
  output logic       turn,
  output logic [1:0] field,
  output logic [2:0] cursor,
  output logic [3:0] disp_digit,
  output logic       move_valid,
  output logic [5:0] move_src,
  output logic [5:0] move_dst
);

  entry_state_t state_q, state_d;
  logic         turn_q, turn_d;
  logic [2:0]   src_file_q, src_file_d;
  logic [2:0]   src_rank_q, src_rank_d;
  logic [2:0]   dst_file_q, dst_file_d;
  logic [2:0]   dst_rank_q, dst_rank_d;

  logic         cmd_valid;
  cmd_t         cmd;
  logic         cnt_en, cnt_up, cnt_clr;
  logic [2:0]   cursor_val;

  // Grant: only the player on turn is heard, and nobody during COMMIT.
  // The off-turn request is simply dropped, so the two can never collide.
  assign w_ready = !turn_q && (state_q != COMMIT);
  assign b_ready =  turn_q && (state_q != COMMIT);

  always_comb begin
    cmd_valid = 1'b0;
    cmd       = CMD_UP;
    if (w_ready && w_valid) begin
      cmd_valid = 1'b1;
      cmd       = cmd_t'(w_cmd);
    end else if (b_ready && b_valid) begin
      cmd_valid = 1'b1;
      cmd       = cmd_t'(b_cmd);
    end
  end

  wrap_counter8 u_cursor (
    .clk   (clk),
    .reset (reset),
    .en    (cnt_en),
    .up    (cnt_up),
    .clr   (cnt_clr),
    .count (cursor_val)
  );

  // Next-state and strobe logic.
  always_comb begin
    state_d    = state_q;
    turn_d     = turn_q;
    src_file_d = src_file_q;
    src_rank_d = src_rank_q;
    dst_file_d = dst_file_q;
    dst_rank_d = dst_rank_q;
    cnt_en     = 1'b0;
    cnt_up     = 1'b0;
    cnt_clr    = 1'b0;
    move_valid = 1'b0;

    if (state_q == COMMIT) begin
      // Strobe the latched squares, then start fresh for the other player.
      move_valid = 1'b1;
      state_d    = SRC_FILE;
      turn_d     = ~turn_q;
      cnt_clr    = 1'b1;
      src_file_d = 3'd0;
      src_rank_d = 3'd0;
      dst_file_d = 3'd0;
      dst_rank_d = 3'd0;
    end else if (cmd_valid) begin
      unique case (cmd)
        CMD_UP: begin
          cnt_en = 1'b1;
          cnt_up = 1'b1;
        end
        CMD_DOWN: begin
          cnt_en = 1'b1;
        end
        CMD_NEXT: begin
          cnt_clr = 1'b1;
          unique case (state_q)
            SRC_FILE: begin src_file_d = cursor_val; state_d = SRC_RANK; end
            SRC_RANK: begin src_rank_d = cursor_val; state_d = DST_FILE; end
            DST_FILE: begin dst_file_d = cursor_val; state_d = DST_RANK; end
            default:  begin dst_rank_d = cursor_val; state_d = COMMIT;   end
          endcase
        end
        default: begin  // CMD_CANCEL: abandon the partial move, keep the turn
          cnt_clr    = 1'b1;
          state_d    = SRC_FILE;
          src_file_d = 3'd0;
          src_rank_d = 3'd0;
          dst_file_d = 3'd0;
          dst_rank_d = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= SRC_FILE;
      turn_q     <= 1'b0;
      // NOTE: the field registers are reset too, so move_src/move_dst read
      // zero straight out of reset instead of leftover squares.
      src_file_q <= 3'd0;
      src_rank_q <= 3'd0;
      dst_file_q <= 3'd0;
      dst_rank_q <= 3'd0;
    end else begin
      state_q    <= state_d;
      turn_q     <= turn_d;
      src_file_q <= src_file_d;
      src_rank_q <= src_rank_d;
      dst_file_q <= dst_file_d;
      dst_rank_q <= dst_rank_d;
    end
  end

  // During COMMIT the field stays on the last edited one (dst rank).
  assign field      = (state_q == COMMIT) ? 2'd3 : state_q[1:0];
  assign turn       = turn_q;
  assign cursor     = cursor_val;
  assign disp_digit = {1'b0, cursor_val};
  assign move_src   = {src_rank_q, src_file_q};
  assign move_dst   = {dst_rank_q, dst_file_q};

endmodule

// File: tb/tb_move_entry_ctrl.sv
// Self-checking bench for move_entry_ctrl: directed scenarios plus a
// randomized run compared against a behavioural model of the move rules.
module tb_move_entry_ctrl;
  import chess_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       w_valid = 1'b0, b_valid = 1'b0;
  logic [1:0] w_cmd = 2'b00, b_cmd = 2'b00;
  logic       w_ready, b_ready, turn, move_valid;
  logic [1:0] field;
  logic [2:0] cursor;
  logic [3:0] disp_digit;
  logic [5:0] move_src, move_dst;

  int checks = 0;
  int errors = 0;

  // Behavioural model: phase 0..3 = field being edited, 4 = commit cycle.
  int m_turn, m_phase, m_cursor;
  int m_fld[4];

  always #5 clk = ~clk;

  move_entry_ctrl dut (
    .clk(clk), .reset(reset),
    .w_valid(w_valid), .w_cmd(w_cmd), .w_ready(w_ready),
    .b_valid(b_valid), .b_cmd(b_cmd), .b_ready(b_ready),
    .turn(turn), .field(field), .cursor(cursor), .disp_digit(disp_digit),
    .move_valid(move_valid), .move_src(move_src), .move_dst(move_dst)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_turn = 0; m_phase = 0; m_cursor = 0;
    for (int i = 0; i < 4; i++) m_fld[i] = 0;
  endtask

  task automatic model_step(input bit wv, input int wc, input bit bv, input int bc);
    bit v;
    int c;
    if (m_phase == 4) begin
      m_phase = 0; m_turn = 1 - m_turn; m_cursor = 0;
      for (int i = 0; i < 4; i++) m_fld[i] = 0;
      return;
    end
    v = (m_turn == 0) ? wv : bv;
    c = (m_turn == 0) ? wc : bc;
    if (!v) return;
    case (c)
      0: m_cursor = (m_cursor + 1) % 8;
      1: m_cursor = (m_cursor + 7) % 8;
      2: begin m_fld[m_phase] = m_cursor; m_cursor = 0; m_phase++; end
      default: begin
        m_phase = 0; m_cursor = 0;
        for (int i = 0; i < 4; i++) m_fld[i] = 0;
      end
    endcase
  endtask

  // Drive one cycle of requests; returns 1 time unit after the clock edge.
  task automatic do_cycle(input bit wv, input logic [1:0] wc, input bit bv, input logic [1:0] bc);
    @(negedge clk);
    w_valid = wv; w_cmd = wc; b_valid = bv; b_cmd = bc;
    @(posedge clk);
    model_step(wv, int'(wc), bv, int'(bc));
    #1;
    w_valid = 1'b0; b_valid = 1'b0;
  endtask

  // Issue a command from whichever player currently holds the turn.
  task automatic send(input cmd_t c);
    if (m_turn == 1) do_cycle(1'b0, CMD_UP, 1'b1, c);
    else             do_cycle(1'b1, c, 1'b0, CMD_UP);
  endtask

  task automatic send_n(input cmd_t c, input int n);
    for (int i = 0; i < n; i++) send(c);
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({w_ready, b_ready, turn, field, cursor, disp_digit, move_valid, move_src, move_dst} !== 25'h100_0000) begin
      errors++;
      $display("FAIL reset_initial: got %b expected %b",
               {w_ready, b_ready, turn, field, cursor, disp_digit, move_valid, move_src, move_dst}, 25'h100_0000);
    end
    @(negedge clk); reset = 1'b0; model_reset();
    send_n(CMD_UP, 3); send(CMD_NEXT); send_n(CMD_UP, 2);
    checks++;
    if (cursor !== 3'd2 || field !== 2'd1) begin
      errors++; $display("FAIL reset_preload: cursor %0d field %0d expected 2 1", cursor, field);
    end
    #3 reset = 1'b1;  // mid-cycle, no clock edge follows before the check
    #1;
    checks++;
    if ({w_ready, b_ready, turn, field, cursor, disp_digit, move_valid, move_src, move_dst} !== 25'h100_0000) begin
      errors++;
      $display("FAIL reset_async: got %b expected %b",
               {w_ready, b_ready, turn, field, cursor, disp_digit, move_valid, move_src, move_dst}, 25'h100_0000);
    end
    @(negedge clk); reset = 1'b0; model_reset();
  endtask

  task automatic test_cursor_wrap();
    for (int i = 1; i <= 8; i++) begin
      send(CMD_UP);
      checks++;
      if (cursor !== 3'(i % 8) || disp_digit !== 4'(i % 8)) begin
        errors++; $display("FAIL wrap_up_%0d: cursor %0d disp %0d expected %0d", i, cursor, disp_digit, i % 8);
      end
    end
    send(CMD_DOWN);
    checks++;
    if (cursor !== 3'd7) begin
      errors++; $display("FAIL wrap_down: cursor %0d expected 7", cursor);
    end
  endtask

  task automatic test_off_turn();
    checks++;
    if (w_ready !== 1'b1 || b_ready !== 1'b0) begin
      errors++; $display("FAIL off_turn_ready: w %b b %b expected 1 0", w_ready, b_ready);
    end
    do_cycle(1'b1, CMD_UP, 1'b1, CMD_UP);  // both ask; only white counts
    checks++;
    if (cursor !== m_cursor[2:0]) begin
      errors++; $display("FAIL off_turn_both: cursor %0d expected %0d", cursor, m_cursor);
    end
    do_cycle(1'b0, CMD_UP, 1'b1, CMD_DOWN);  // black alone is ignored
    checks++;
    if (cursor !== m_cursor[2:0] || turn !== 1'b0) begin
      errors++; $display("FAIL off_turn_black: cursor %0d turn %b expected %0d 0", cursor, turn, m_cursor);
    end
  endtask

  task automatic test_cancel();
    send(CMD_CANCEL);
    send_n(CMD_UP, 2); send(CMD_NEXT); send_n(CMD_UP, 3); send(CMD_NEXT);
    send_n(CMD_UP, 5);
    checks++;
    if (field !== 2'd2 || cursor !== 3'd5) begin
      errors++; $display("FAIL cancel_setup: field %0d cursor %0d expected 2 5", field, cursor);
    end
    send(CMD_CANCEL);
    checks++;
    if ({field, cursor, turn, move_valid, move_src, move_dst} !== 19'd0) begin
      errors++; $display("FAIL cancel_clear: field %0d cursor %0d turn %b mv %b src %o dst %o expected all 0",
                         field, cursor, turn, move_valid, move_src, move_dst);
    end
    for (int i = 0; i < 3; i++) begin
      do_cycle(1'b0, CMD_UP, 1'b0, CMD_UP);
      checks++;
      if (move_valid !== 1'b0 || w_ready !== 1'b1) begin
        errors++; $display("FAIL cancel_idle_%0d: mv %b w_ready %b expected 0 1", i, move_valid, w_ready);
      end
    end
  endtask

  task automatic test_full_move();
    send_n(CMD_UP, 4); send(CMD_NEXT);
    send_n(CMD_UP, 1); send(CMD_NEXT);
    send_n(CMD_UP, 4); send(CMD_NEXT);
    send_n(CMD_UP, 3); send(CMD_NEXT);
    checks++;
    if (move_valid !== 1'b1 || move_src !== 6'o14 || move_dst !== 6'o34) begin
      errors++; $display("FAIL full_move_strobe: mv %b src %o dst %o expected 1 14 34", move_valid, move_src, move_dst);
    end
    checks++;
    if (w_ready !== 1'b0 || b_ready !== 1'b0 || turn !== 1'b0) begin
      errors++; $display("FAIL full_move_commit_ready: w %b b %b turn %b expected 0 0 0", w_ready, b_ready, turn);
    end
    do_cycle(1'b1, CMD_UP, 1'b1, CMD_UP);  // dropped during COMMIT
    checks++;
    if (turn !== 1'b1 || move_valid !== 1'b0 || b_ready !== 1'b1 || w_ready !== 1'b0
        || cursor !== 3'd0 || field !== 2'd0) begin
      errors++; $display("FAIL full_move_handover: turn %b mv %b w %b b %b cursor %0d field %0d expected 1 0 0 1 0 0",
                         turn, move_valid, w_ready, b_ready, cursor, field);
    end
  endtask

  task automatic test_reset_commit();
    send_n(CMD_UP, 2); send(CMD_NEXT); send(CMD_UP); send(CMD_NEXT);
    send(CMD_NEXT); send_n(CMD_UP, 7); send(CMD_NEXT);
    checks++;
    if (move_valid !== 1'b1 || move_src !== 6'o12 || move_dst !== 6'o70) begin
      errors++; $display("FAIL rc_strobe: mv %b src %o dst %o expected 1 12 70", move_valid, move_src, move_dst);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (move_valid !== 1'b0 || turn !== 1'b0 || w_ready !== 1'b1 || b_ready !== 1'b0) begin
      errors++; $display("FAIL rc_async: mv %b turn %b w %b b %b expected 0 0 1 0", move_valid, turn, w_ready, b_ready);
    end
    @(negedge clk); reset = 1'b0; model_reset();
    for (int i = 0; i < 5; i++) begin
      do_cycle(1'b0, CMD_UP, 1'b0, CMD_UP);
      checks++;
      if (move_valid !== 1'b0 || turn !== 1'b0) begin
        errors++; $display("FAIL rc_after_%0d: mv %b turn %b expected 0 0", i, move_valid, turn);
      end
    end
  endtask

  function automatic logic [1:0] rand_cmd();
    int r;
    r = $urandom_range(0, 19);
    if (r < 6)  return CMD_UP;
    if (r < 10) return CMD_DOWN;
    if (r < 19) return CMD_NEXT;
    return CMD_CANCEL;
  endfunction

  task automatic test_random();
    int commits = 0;
    for (int i = 0; i < 600; i++) begin
      bit exp_wr, exp_br;
      do_cycle(1'($urandom_range(0, 1)), rand_cmd(), 1'($urandom_range(0, 1)), rand_cmd());
      exp_wr = (m_turn == 0) && (m_phase != 4);
      exp_br = (m_turn == 1) && (m_phase != 4);
      checks++;
      if (cursor !== m_cursor[2:0] || disp_digit !== {1'b0, m_cursor[2:0]} || turn !== 1'(m_turn)) begin
        errors++; $display("FAIL rnd_%0d_core: cursor %0d disp %0d turn %b expected %0d %0d %0d",
                           i, cursor, disp_digit, turn, m_cursor, m_cursor, m_turn);
      end
      checks++;
      if (move_valid !== (m_phase == 4) || w_ready !== exp_wr || b_ready !== exp_br) begin
        errors++; $display("FAIL rnd_%0d_ctrl: mv %b w %b b %b expected %b %b %b",
                           i, move_valid, w_ready, b_ready, m_phase == 4, exp_wr, exp_br);
      end
      if (m_phase < 4) begin
        checks++;
        if (field !== 2'(m_phase)) begin
          errors++; $display("FAIL rnd_%0d_field: got %0d expected %0d", i, field, m_phase);
        end
      end else begin
        commits++;
        checks++;
        if (move_src !== 6'(m_fld[1] * 8 + m_fld[0]) || move_dst !== 6'(m_fld[3] * 8 + m_fld[2])) begin
          errors++; $display("FAIL rnd_%0d_move: src %o dst %o expected %o %o", i, move_src, move_dst,
                             m_fld[1] * 8 + m_fld[0], m_fld[3] * 8 + m_fld[2]);
        end
      end
    end
    checks++;
    if (commits < 5) begin
      errors++; $display("FAIL rnd_commit_count: got %0d expected at least 5", commits);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_cursor_wrap();
    test_off_turn();
    test_cancel();
    test_full_move();
    test_reset_commit();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
